// File: rtl/rob_mw_pkg.sv
// Shared types for the multi-width reorder buffer: entry layout, index and
// address types, default sizing, and the writeback resolution helper.
package rob_mw_pkg;

   localparam int ROB_SZ           = 32;
   localparam int N                = 2;
   localparam int FU_ROB_PACKET_SZ = 2;
   localparam int ROBN_W           = $clog2(ROB_SZ);

   typedef logic [31:0]       ADDR;
   typedef logic [ROBN_W-1:0] ROBN;

   typedef struct packed {
      ADDR  pc;
      ADDR  npc;
      logic cond_branch;
      logic uncond_branch;
      logic halt;
      logic predict_taken;
      ADDR  predict_target;
      logic executed;
      logic success;
      logic resolve_taken;
      ADDR  resolve_target;
   } ROB_ENTRY;

   // Fold a completion report into an entry. Only branches can lose success;
   // other entries keep the success=1 they were dispatched with.
   function automatic ROB_ENTRY rob_apply_wb(input ROB_ENTRY e, input logic taken, input ADDR target);
      ROB_ENTRY r;
      r                = e;
      r.executed       = 1'b1;
      r.resolve_taken  = taken;
      r.resolve_target = taken ? target : e.npc;
      r.success        = (e.cond_branch || e.uncond_branch)
                         ? ((taken == e.predict_taken) && (r.resolve_target == e.predict_target))
                         : e.success;
      return r;
   endfunction

endpackage

// File: rtl/rob_ptr_wrap.sv
// Adds a small offset (at most the dispatch/commit width) to a ROB index and
// wraps it back into 0..SIZE-1 without a modulo, so non-power-of-two depths work.
module rob_ptr_wrap #(
   parameter  int SIZE  = 32,
   parameter  int OFF_W = 2,
   localparam int IW    = $clog2(SIZE),
   localparam int SW    = IW + 1
) (
   input  logic [IW-1:0]    idx,
   input  logic [OFF_W-1:0] off,
   output logic [IW-1:0]    res
);

   logic [SW-1:0] sum_s;

   // One conditional subtraction suffices because idx < SIZE and off <= SIZE.
   always_comb begin
      sum_s = SW'(idx) + SW'(off);
      if (sum_s >= SW'(SIZE)) begin
         res = IW'(sum_s - SW'(SIZE));
      end else begin
         res = IW'(sum_s);
      end
   end

endmodule

// File: rtl/rob_mw.sv
// Multi-width reorder buffer: in-order group dispatch with an exact free-slot
// count, out-of-order completion, in-order multi-lane retirement, squash with
// redirect PC and a sticky halt.
module rob_mw
   import rob_mw_pkg::*;
#(
   parameter  int SIZE       = ROB_SZ,
   parameter  int DISPATCH_W = N,
   parameter  int COMMIT_W   = N,
   parameter  int WB_W       = FU_ROB_PACKET_SZ,
   localparam int IW         = $clog2(SIZE),
   localparam int CW         = $clog2(SIZE + 1)
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [DISPATCH_W-1:0]         disp_valid,
   input  ROB_ENTRY [DISPATCH_W-1:0]     disp_entry,
   output logic                          disp_accept,
   output ROBN [DISPATCH_W-1:0]          disp_robn,
   output logic [CW-1:0]                 free_slots,
   input  logic [WB_W-1:0]               wb_valid,
   input  ROBN [WB_W-1:0]                wb_robn,
   input  logic [WB_W-1:0]               wb_taken,
   input  ADDR [WB_W-1:0]                wb_target,
   output logic [COMMIT_W-1:0]           ct_valid,
   output ROB_ENTRY [COMMIT_W-1:0]       ct_entry,
   output logic                          squash,
   output ADDR                           squash_pc,
   output logic                          halted
);

   localparam int MAXW = (DISPATCH_W > COMMIT_W) ? DISPATCH_W : COMMIT_W;
   localparam int OW   = $clog2(MAXW + 1);

   // Registered state
   ROB_ENTRY        entries_r [SIZE];
   logic [SIZE-1:0] valid_r;
   logic [IW-1:0]   head_r;
   logic [IW-1:0]   tail_r;
   logic [CW-1:0]   count_r;
   logic            halted_r;

   // Dispatch-side combinational signals
   logic [OW-1:0]   disp_off_s [DISPATCH_W];
   logic [IW-1:0]   disp_idx_s [DISPATCH_W];
   logic [CW-1:0]   disp_cnt_s;
   logic [CW-1:0]   acc_cnt_s;
   logic [CW-1:0]   free_s;
   logic            accept_s;
   ROB_ENTRY [DISPATCH_W-1:0] disp_wr_s;

   // Commit-side combinational signals
   logic [IW-1:0]   ct_idx_s [COMMIT_W];
   logic [COMMIT_W-1:0]       ct_valid_s;
   ROB_ENTRY [COMMIT_W-1:0]   ct_entry_s;
   logic [CW-1:0]   ret_cnt_s;
   logic            go_s;
   logic            squash_s;
   ADDR             squash_pc_s;
   logic            halt_ret_s;

   // Writeback and pointer-advance signals
   logic [IW-1:0]   wb_idx_s [WB_W];
   logic [WB_W-1:0] wb_hit_s;
   logic [IW-1:0]   head_next_s;
   logic [IW-1:0]   tail_next_s;

   // Per-lane slot offset: number of valid lanes below each lane, plus group size.
   always_comb begin
      disp_cnt_s = '0;
      for (int i = 0; i < DISPATCH_W; i++) begin
         disp_off_s[i] = OW'(disp_cnt_s);
         disp_cnt_s    = disp_cnt_s + CW'(disp_valid[i]);
      end
   end

   for (genvar i = 0; i < DISPATCH_W; i++) begin : g_disp_ptr
      rob_ptr_wrap #(.SIZE(SIZE), .OFF_W(OW)) u_disp_ptr (
         .idx (tail_r),
         .off (disp_off_s[i]),
         .res (disp_idx_s[i])
      );
   end

   for (genvar k = 0; k < COMMIT_W; k++) begin : g_ct_ptr
      localparam logic [OW-1:0] LANE_OFF = OW'(k);
      rob_ptr_wrap #(.SIZE(SIZE), .OFF_W(OW)) u_ct_ptr (
         .idx (head_r),
         .off (LANE_OFF),
         .res (ct_idx_s[k])
      );
   end

   rob_ptr_wrap #(.SIZE(SIZE), .OFF_W(OW)) u_head_next (
      .idx (head_r),
      .off (OW'(ret_cnt_s)),
      .res (head_next_s)
   );

   rob_ptr_wrap #(.SIZE(SIZE), .OFF_W(OW)) u_tail_next (
      .idx (tail_r),
      .off (OW'(acc_cnt_s)),
      .res (tail_next_s)
   );

   // In-order retirement from registered state; a lane retires only if all
   // earlier lanes did, and the scan stops after a mispredict or a halt.
   always_comb begin
      go_s        = !halted_r;
      ret_cnt_s   = '0;
      squash_s    = 1'b0;
      squash_pc_s = 32'h0000_0000;
      halt_ret_s  = 1'b0;
      ct_valid_s  = '0;
      ct_entry_s  = '0;
      for (int k = 0; k < COMMIT_W; k++) begin
         if (go_s && (count_r > CW'(k)) && valid_r[ct_idx_s[k]] && entries_r[ct_idx_s[k]].executed) begin
            ct_valid_s[k] = 1'b1;
            ct_entry_s[k] = entries_r[ct_idx_s[k]];
            ret_cnt_s     = ret_cnt_s + CW'(1);
            squash_s      = !entries_r[ct_idx_s[k]].success;
            squash_pc_s   = entries_r[ct_idx_s[k]].success ? 32'h0000_0000
                                                           : entries_r[ct_idx_s[k]].resolve_target;
            halt_ret_s    = entries_r[ct_idx_s[k]].halt;
            go_s          = entries_r[ct_idx_s[k]].success && !entries_r[ct_idx_s[k]].halt;
         end else begin
            go_s = 1'b0;
         end
      end
   end

   // Group acceptance against the registered free count; also the dispatched entry image.
   always_comb begin
      free_s    = CW'(SIZE) - count_r;
      accept_s  = !squash_s && !halted_r && (disp_cnt_s <= free_s);
      acc_cnt_s = accept_s ? disp_cnt_s : '0;
      disp_wr_s = '0;
      for (int i = 0; i < DISPATCH_W; i++) begin
         disp_wr_s[i]          = disp_entry[i];
         disp_wr_s[i].executed = 1'b0;
         disp_wr_s[i].success  = 1'b1;
      end
   end

   // Writeback port decode; reports to free or out-of-range slots are dropped.
   always_comb begin
      wb_hit_s = '0;
      for (int p = 0; p < WB_W; p++) begin
         wb_idx_s[p] = wb_robn[p][IW-1:0];
         wb_hit_s[p] = wb_valid[p] && (int'(wb_robn[p]) < SIZE) && valid_r[wb_idx_s[p]];
      end
   end

   // Control state: pointers, occupancy, valid bits and the sticky halt flag.
   always_ff @(posedge clock) begin
      if (reset) begin
         head_r   <= '0;
         tail_r   <= '0;
         count_r  <= '0;
         valid_r  <= '0;
         halted_r <= 1'b0;
      end else if (squash_s) begin
         head_r   <= '0;
         tail_r   <= '0;
         count_r  <= '0;
         valid_r  <= '0;
         halted_r <= halted_r | halt_ret_s;
      end else begin
         head_r   <= head_next_s;
         tail_r   <= tail_next_s;
         count_r  <= count_r - ret_cnt_s + acc_cnt_s;
         halted_r <= halted_r | halt_ret_s;
         for (int k = 0; k < COMMIT_W; k++) begin
            if (ct_valid_s[k]) begin
               valid_r[ct_idx_s[k]] <= 1'b0;
            end
         end
         for (int i = 0; i < DISPATCH_W; i++) begin
            if (accept_s && disp_valid[i]) begin
               valid_r[disp_idx_s[i]] <= 1'b1;
            end
         end
      end
   end

   // Entry payload: writebacks (later port wins) then dispatch into free slots.
   always_ff @(posedge clock) begin
      if (!reset && !squash_s) begin
         for (int p = 0; p < WB_W; p++) begin
            if (wb_hit_s[p]) begin
               entries_r[wb_idx_s[p]] <= rob_apply_wb(entries_r[wb_idx_s[p]], wb_taken[p], wb_target[p]);
            end
         end
         for (int i = 0; i < DISPATCH_W; i++) begin
            if (accept_s && disp_valid[i]) begin
               entries_r[disp_idx_s[i]] <= disp_wr_s[i];
            end
         end
      end
   end

   // Output drive
   always_comb begin
      disp_accept = accept_s;
      free_slots  = free_s;
      ct_valid    = ct_valid_s;
      ct_entry    = ct_entry_s;
      squash      = squash_s;
      squash_pc   = squash_pc_s;
      halted      = halted_r;
      for (int i = 0; i < DISPATCH_W; i++) begin
         disp_robn[i] = ROBN'(disp_idx_s[i]);
      end
   end

endmodule

// File: tb/tb_rob_mw.sv
// Self-checking bench for rob_mw (SIZE=6 to exercise wrap). A queue-based
// reference model predicts every output each cycle; directed steps cover the
// key scenarios, then a randomized phase runs against the same model.
module tb_rob_mw;
   import rob_mw_pkg::*;

   localparam int SZ = 6;
   localparam int DW = 2;
   localparam int CL = 2;
   localparam int WW = 2;
   localparam int CW = $clog2(SZ + 1);

   logic               clock;
   logic               reset;
   logic [DW-1:0]      disp_valid;
   ROB_ENTRY [DW-1:0]  disp_entry;
   logic               disp_accept;
   ROBN [DW-1:0]       disp_robn;
   logic [CW-1:0]      free_slots;
   logic [WW-1:0]      wb_valid;
   ROBN [WW-1:0]       wb_robn;
   logic [WW-1:0]      wb_taken;
   ADDR [WW-1:0]       wb_target;
   logic [CL-1:0]      ct_valid;
   ROB_ENTRY [CL-1:0]  ct_entry;
   logic               squash;
   ADDR                squash_pc;
   logic               halted;

   rob_mw #(.SIZE(SZ), .DISPATCH_W(DW), .COMMIT_W(CL), .WB_W(WW)) dut (
      .clock       (clock),
      .reset       (reset),
      .disp_valid  (disp_valid),
      .disp_entry  (disp_entry),
      .disp_accept (disp_accept),
      .disp_robn   (disp_robn),
      .free_slots  (free_slots),
      .wb_valid    (wb_valid),
      .wb_robn     (wb_robn),
      .wb_taken    (wb_taken),
      .wb_target   (wb_target),
      .ct_valid    (ct_valid),
      .ct_entry    (ct_entry),
      .squash      (squash),
      .squash_pc   (squash_pc),
      .halted      (halted)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Reference model: occupied entries oldest-first, head index, halt flag.
   ROB_ENTRY mq[$];
   int       m_head;
   bit       m_halted;

   int checks;
   int errors;

   // Per-cycle predictions
   int       e_free;
   int       n_ret;
   bit       e_accept;
   bit       e_squash;
   bit       e_halt;
   ADDR      e_pc;
   int       e_robn [DW];
   bit       e_ctv  [CL];
   ROB_ENTRY e_ct   [CL];

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic ROB_ENTRY model_wb(input ROB_ENTRY e, input bit tk, input ADDR tg);
      ROB_ENTRY r;
      r               = e;
      r.executed      = 1'b1;
      r.resolve_taken = tk;
      r.resolve_target = tk ? tg : e.npc;
      if (e.cond_branch || e.uncond_branch)
         r.success = (tk == e.predict_taken) && (r.resolve_target == e.predict_target);
      return r;
   endfunction

   // Expected outputs from the model state and the current inputs.
   task automatic predict();
      int nreq;
      int below;
      bit go;
      n_ret = 0; e_squash = 0; e_halt = 0; e_pc = 32'h0;
      go = !m_halted;
      for (int k = 0; k < CL; k++) begin
         e_ctv[k] = 1'b0;
         e_ct[k]  = '0;
         if (go && k < mq.size() && mq[k].executed) begin
            e_ctv[k] = 1'b1;
            e_ct[k]  = mq[k];
            n_ret++;
            if (!mq[k].success) begin e_squash = 1; e_pc = mq[k].resolve_target; go = 0; end
            if (mq[k].halt) begin e_halt = 1; go = 0; end
         end else begin
            go = 0;
         end
      end
      nreq = 0;
      for (int i = 0; i < DW; i++) nreq += int'(disp_valid[i]);
      e_free   = SZ - mq.size();
      e_accept = !e_squash && !m_halted && (nreq <= e_free);
      below = 0;
      for (int i = 0; i < DW; i++) begin
         e_robn[i] = (m_head + mq.size() + below) % SZ;
         if (disp_valid[i]) below++;
      end
   endtask

   // Apply one clock edge to the model.
   task automatic advance();
      int pos;
      ROB_ENTRY e;
      if (reset) begin
         mq.delete(); m_head = 0; m_halted = 0;
      end else if (e_squash) begin
         m_halted = m_halted | e_halt;
         mq.delete(); m_head = 0;
      end else begin
         for (int p = 0; p < WW; p++) begin
            if (wb_valid[p] && int'(wb_robn[p]) < SZ) begin
               pos = (int'(wb_robn[p]) - m_head + SZ) % SZ;
               if (pos < mq.size()) mq[pos] = model_wb(mq[pos], wb_taken[p], wb_target[p]);
            end
         end
         for (int k = 0; k < n_ret; k++) void'(mq.pop_front());
         m_head   = (m_head + n_ret) % SZ;
         m_halted = m_halted | e_halt;
         if (e_accept) begin
            for (int i = 0; i < DW; i++) begin
               if (disp_valid[i]) begin
                  e = disp_entry[i];
                  e.executed = 1'b0;
                  e.success  = 1'b1;
                  mq.push_back(e);
               end
            end
         end
      end
   endtask

   task automatic step();
      #1;
      predict();
      if (!reset) begin
         check("free_slots", free_slots, e_free);
         check("disp_accept", disp_accept, e_accept);
         for (int i = 0; i < DW; i++) check($sformatf("disp_robn%0d", i), disp_robn[i], e_robn[i]);
         for (int k = 0; k < CL; k++) begin
            check($sformatf("ct_valid%0d", k), ct_valid[k], e_ctv[k]);
            check($sformatf("ct_entry%0d", k), ct_entry[k], e_ct[k]);
         end
         check("squash", squash, e_squash);
         check("squash_pc", squash_pc, e_pc);
         check("halted", halted, m_halted);
      end
      @(posedge clock);
      advance();
      #1;
   endtask

   task automatic idle();
      disp_valid = '0; disp_entry = '0;
      wb_valid = '0; wb_robn = '0; wb_taken = '0; wb_target = '0;
   endtask

   task automatic set_wb(input int p, input int robn, input bit tk, input ADDR tg);
      wb_valid[p]  = 1'b1;
      wb_robn[p]   = ROBN'(robn);
      wb_taken[p]  = tk;
      wb_target[p] = tg;
   endtask

   // Garbage in executed/success/resolve fields: dispatch must override or ignore them.
   function automatic ROB_ENTRY plain_entry(input int id);
      ROB_ENTRY e;
      e = '0;
      e.pc = 32'(id) * 32'd16;
      e.npc = e.pc + 32'd4;
      e.executed = 1'b1;
      e.resolve_target = 32'hDEAD_0000;
      return e;
   endfunction

   function automatic ADDR pick_tgt();
      return ($urandom_range(0, 1) == 0) ? 32'h0000_0100 : 32'h0000_0200;
   endfunction

   function automatic ROB_ENTRY rand_entry(input bit allow_halt);
      ROB_ENTRY e;
      int kind;
      e = '0;
      e.pc             = 32'($urandom_range(0, 1023)) << 2;
      e.npc            = e.pc + 32'd4;
      kind             = $urandom_range(0, 9);
      e.cond_branch    = (kind <= 2);
      e.uncond_branch  = (kind == 3);
      e.halt           = allow_halt && (kind >= 4);
      e.predict_taken  = 1'($urandom_range(0, 1));
      e.predict_target = pick_tgt();
      e.executed       = 1'($urandom_range(0, 1));
      e.success        = 1'($urandom_range(0, 1));
      e.resolve_taken  = 1'($urandom_range(0, 1));
      e.resolve_target = $urandom;
      return e;
   endfunction

   initial begin
      ROB_ENTRY b;
      checks = 0; errors = 0;
      m_head = 0; m_halted = 0;
      idle();
      reset = 1'b1;
      step(); step();
      reset = 1'b0;

      // Reset state with no lanes requesting
      step();

      // Fill: three full groups, then a group is rejected while full
      for (int g = 0; g < 3; g++) begin
         disp_valid = 2'b11;
         disp_entry[0] = plain_entry(2 * g);
         disp_entry[1] = plain_entry(2 * g + 1);
         step();
      end
      disp_valid = 2'b01; disp_entry[0] = plain_entry(9);
      step();
      idle();

      // Out-of-order completion: 2, 1, then 0 unblocks retirement
      set_wb(0, 2, 1'b0, 32'h0); step(); idle();
      set_wb(0, 1, 1'b1, 32'h0000_0040); step(); idle();
      set_wb(0, 0, 1'b0, 32'h0); step(); idle();
      step();
      step();

      // Same-entry collision (port 1 wins) and a report to a free slot
      set_wb(0, 5, 1'b0, 32'h0); set_wb(1, 5, 1'b1, 32'h0000_0300); step(); idle();
      set_wb(0, 0, 1'b1, 32'h0000_0500); set_wb(1, 3, 1'b0, 32'h0); step(); idle();
      set_wb(0, 4, 1'b0, 32'h0); step(); idle();
      step();

      // Mispredicted branch with younger executed entry, dispatch in squash cycle
      b = plain_entry(21);
      b.cond_branch = 1'b1; b.predict_taken = 1'b0; b.predict_target = 32'h0000_0200;
      disp_valid = 2'b11; disp_entry[0] = plain_entry(20); disp_entry[1] = b;
      step(); idle();
      set_wb(0, 0, 1'b0, 32'h0); set_wb(1, 1, 1'b1, 32'h0000_0100); step(); idle();
      disp_valid = 2'b11; disp_entry[0] = plain_entry(22); disp_entry[1] = plain_entry(23);
      step(); idle();
      step();

      // Halt followed by an executed entry: only the halt retires, then frozen
      b = plain_entry(30); b.halt = 1'b1;
      disp_valid = 2'b11; disp_entry[0] = b; disp_entry[1] = plain_entry(31);
      step(); idle();
      set_wb(0, 0, 1'b0, 32'h0); set_wb(1, 1, 1'b0, 32'h0); step(); idle();
      step();
      disp_valid = 2'b11; disp_entry[0] = plain_entry(32); disp_entry[1] = plain_entry(33);
      step(); idle();
      step();
      reset = 1'b1; step(); reset = 1'b0;

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         reset = (m_halted && $urandom_range(0, 5) == 0) || ($urandom_range(0, 299) == 0);
         for (int i = 0; i < DW; i++) begin
            disp_valid[i] = ($urandom_range(0, 3) != 0);
            disp_entry[i] = rand_entry($urandom_range(0, 40) == 0);
         end
         for (int p = 0; p < WW; p++) begin
            wb_valid[p]  = 1'($urandom_range(0, 1));
            wb_robn[p]   = ROBN'($urandom_range(0, SZ - 1));
            wb_taken[p]  = 1'($urandom_range(0, 1));
            wb_target[p] = pick_tgt();
         end
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
